// File: rtl/param_shift_pipe_if.sv
// Bus bundle for param_shift_pipe: producer-side controls/data in, pipeline
// outputs back. The pipe itself connects through the slave modport.
interface param_shift_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = (DEPTH > 2) ? $clog2(DEPTH + 1) : 2
);
    logic             en;
    logic             flush;
    logic             d_valid;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CNT_W-1:0] occ;
    logic             perr;

    modport master (
        output en, flush, d_valid, d,
        input  q, q_valid, occ, perr
    );

    modport slave (
        input  en, flush, d_valid, d,
        output q, q_valid, occ, perr
    );
endinterface

// File: rtl/param_shift_pipe.sv
// param_shift_pipe: stallable, flushable, valid-tagged delay line of DEPTH
// register stages with an occupancy counter. All outputs come straight from
// registers. Optional per-stage parity with a sticky error flag is built only
// when PARAM_SHIFT_PIPE_PARITY_EN is defined; otherwise perr is constant 0.
module param_shift_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = (DEPTH > 2) ? $clog2(DEPTH + 1) : 2
) (
    input  logic              clk,
    input  logic              rstn,
    param_shift_pipe_if.slave bus
);

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    // Next-state for data, valid tags and occupancy; flush outranks enable.
    always_comb begin
        s_d   = s_q;
        v_d   = v_q;
        occ_d = occ_q;
        if (bus.flush) begin
            // Data is left in place; only the tags and count are cleared.
            v_d   = {DEPTH{1'b0}};
            occ_d = {CNT_W{1'b0}};
        end else if (bus.en) begin
            s_d[0] = bus.d;
            v_d[0] = bus.d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                s_d[i] = s_q[i-1];
                v_d[i] = v_q[i-1];
            end
            // Entry and exit in the same cycle cancel; bounds 0..DEPTH need no wrap.
            occ_d = occ_q + CNT_W'(bus.d_valid) - CNT_W'(v_q[DEPTH-1]);
        end else begin
            s_d   = s_q;
            v_d   = v_q;
            occ_d = occ_q;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_q[i] <= {WIDTH{1'b0}};
            end
            v_q   <= {DEPTH{1'b0}};
            occ_q <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                s_q[i] <= s_d[i];
            end
            v_q   <= v_d;
            occ_q <= occ_d;
        end
    end

    assign bus.q       = s_q[DEPTH-1];
    assign bus.q_valid = v_q[DEPTH-1];
    assign bus.occ     = occ_q;

`ifdef PARAM_SHIFT_PIPE_PARITY_EN
    // Even-parity bit of one data word.
    function automatic logic parity_f(input logic [WIDTH-1:0] x);
        return ^x;
    endfunction

    logic [DEPTH-1:0] p_q;
    logic [DEPTH-1:0] p_d;
    logic             perr_q;
    logic             perr_d;
    logic             par_bad_s;

    // Parity bits follow the data exactly; the check looks only at stored state.
    always_comb begin
        p_d       = p_q;
        perr_d    = perr_q;
        par_bad_s = bus.q_valid && (parity_f(s_q[DEPTH-1]) != p_q[DEPTH-1]);
        if (bus.flush) begin
            // Data parity holds like the data; only the sticky flag clears.
            p_d    = p_q;
            perr_d = 1'b0;
        end else begin
            if (bus.en) begin
                p_d[0] = parity_f(bus.d);
                for (int i = 1; i < DEPTH; i++) begin
                    p_d[i] = p_q[i-1];
                end
            end else begin
                p_d = p_q;
            end
            if (par_bad_s) begin
                perr_d = 1'b1;
            end else begin
                perr_d = perr_q;
            end
        end
    end

    // Parity shadow registers and sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_q    <= {DEPTH{1'b0}};
            perr_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            perr_q <= perr_d;
        end
    end

    assign bus.perr = perr_q;
`else
    assign bus.perr = 1'b0;
`endif

endmodule

// File: tb/tb_param_shift_pipe.sv
// Self-checking bench for param_shift_pipe: a DEPTH=4 instance checked against
// a queue-based model, plus a WIDTH=1/DEPTH=1 instance for the degenerate case.
module tb_param_shift_pipe;
    localparam int W = 8;
    localparam int D = 4;

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
    } slot_t;

    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    param_shift_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();
    param_shift_pipe_if #(.WIDTH(1), .DEPTH(1)) bus1 ();

    param_shift_pipe #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    param_shift_pipe #(.WIDTH(1), .DEPTH(1)) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the pipe is a fixed-length queue of (valid, data) slots.
    slot_t pipe_m[$];
    logic  m1_v;
    logic  m1_d;

    function automatic logic [2:0] m_occ();
        int n;
        n = 0;
        foreach (pipe_m[i]) if (pipe_m[i].v) n++;
        return 3'(n);
    endfunction

    task automatic model_reset();
        slot_t z;
        z = '0;
        pipe_m.delete();
        repeat (D) pipe_m.push_back(z);
        m1_v = 1'b0;
        m1_d = 1'b0;
    endtask

    // One clock edge: capture the inputs the DUT sees, advance the models.
    task automatic tick();
        logic e, f, dv, e1, f1, dv1, dd1;
        logic [W-1:0] dd;
        slot_t s;
        e = bus.en; f = bus.flush; dv = bus.d_valid; dd = bus.d;
        e1 = bus1.en; f1 = bus1.flush; dv1 = bus1.d_valid; dd1 = bus1.d[0];
        @(posedge clk);
        if (f) begin
            foreach (pipe_m[i]) pipe_m[i].v = 1'b0;
        end else if (e) begin
            s.v = dv;
            s.d = dd;
            pipe_m.push_front(s);
            void'(pipe_m.pop_back());
        end
        if (f1) m1_v = 1'b0;
        else if (e1) begin
            m1_v = dv1;
            m1_d = dd1;
        end
        #1;
    endtask

    task automatic drive(input logic e, input logic f, input logic dv, input logic [W-1:0] dd);
        bus.en = e; bus.flush = f; bus.d_valid = dv; bus.d = dd;
    endtask

    task automatic test_reset();
        if ({bus.q_valid, bus.q, bus.occ, bus.perr} !== {1'b0, 8'h00, 3'd0, 1'b0}) begin
            $display("FAIL reset_init: got v=%b q=%h occ=%0d perr=%b, want all 0",
                     bus.q_valid, bus.q, bus.occ, bus.perr);
            fails++;
        end
        tests++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(8'hA0 + i));
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 8'h77);
        if (bus.occ !== 3'd3) begin
            $display("FAIL reset_preload_occ: got %0d want 3", bus.occ);
            fails++;
        end
        tests++;
        #2 rstn = 1'b0;
        #1;
        if ({bus.q_valid, bus.q, bus.occ, bus.perr} !== {1'b0, 8'h00, 3'd0, 1'b0}) begin
            $display("FAIL reset_midstream: got v=%b q=%h occ=%0d perr=%b, want all 0",
                     bus.q_valid, bus.q, bus.occ, bus.perr);
            fails++;
        end
        tests++;
        model_reset();
        #1 rstn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_fill_drain();
        logic [2:0]   occ_t [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        logic [W-1:0] q_t   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int k = 0; k < 9; k++) begin
            if (k < 5) drive(1'b1, 1'b0, 1'b1, 8'(8'h11 * (k + 1)));
            else       drive(1'b1, 1'b0, 1'b0, 8'(8'hE0 + k));
            tick();
            if (bus.occ !== occ_t[k]) begin
                $display("FAIL fill_occ edge%0d: got %0d want %0d", k + 1, bus.occ, occ_t[k]);
                fails++;
            end
            tests++;
            if (k >= 3 && k <= 7) begin
                if ({bus.q_valid, bus.q} !== {1'b1, q_t[k-3]}) begin
                    $display("FAIL fill_q edge%0d: got v=%b q=%h want v=1 q=%h",
                             k + 1, bus.q_valid, bus.q, q_t[k-3]);
                    fails++;
                end
            end else begin
                if (bus.q_valid !== 1'b0) begin
                    $display("FAIL fill_qv edge%0d: got %b want 0", k + 1, bus.q_valid);
                    fails++;
                end
            end
            tests++;
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b1, 8'h5A); tick();
        drive(1'b1, 1'b0, 1'b1, 8'hC3); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, k[0], 8'($urandom));
            tick();
            if ({bus.q_valid, bus.q, bus.occ} !== {pipe_m[D-1].v, pipe_m[D-1].d, 3'd2}) begin
                $display("FAIL stall_hold c%0d: got v=%b q=%h occ=%0d want v=%b q=%h occ=2",
                         k, bus.q_valid, bus.q, bus.occ, pipe_m[D-1].v, pipe_m[D-1].d);
                fails++;
            end
            tests++;
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'($urandom));
            tick();
            if ({bus.q_valid, bus.q, bus.occ} !== {pipe_m[D-1].v, pipe_m[D-1].d, m_occ()}) begin
                $display("FAIL stall_resume c%0d: got v=%b q=%h occ=%0d want v=%b q=%h occ=%0d",
                         k, bus.q_valid, bus.q, bus.occ, pipe_m[D-1].v, pipe_m[D-1].d, m_occ());
                fails++;
            end
            tests++;
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(8'h31 + k));
            tick();
        end
        if (bus.occ !== 3'd3) begin
            $display("FAIL flush_pre_occ: got %0d want 3", bus.occ);
            fails++;
        end
        tests++;
        drive(1'b1, 1'b1, 1'b1, 8'hAA);
        tick();
        if ({bus.q_valid, bus.occ} !== {1'b0, 3'd0}) begin
            $display("FAIL flush_clear: got v=%b occ=%0d want v=0 occ=0", bus.q_valid, bus.occ);
            fails++;
        end
        tests++;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            tick();
            if (bus.q_valid !== 1'b0 || bus.occ !== 3'd0) begin
                $display("FAIL flush_after c%0d: got v=%b q=%h occ=%0d want v=0 occ=0",
                         k, bus.q_valid, bus.q, bus.occ);
                fails++;
            end
            tests++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(3) != 0), ($urandom_range(11) == 0),
                  ($urandom_range(4) < 3), 8'($urandom));
            tick();
            if ({bus.q_valid, bus.q, bus.occ, bus.perr} !==
                {pipe_m[D-1].v, pipe_m[D-1].d, m_occ(), 1'b0}) begin
                $display("FAIL random c%0d: got v=%b q=%h occ=%0d perr=%b want v=%b q=%h occ=%0d perr=0",
                         k, bus.q_valid, bus.q, bus.occ, bus.perr,
                         pipe_m[D-1].v, pipe_m[D-1].d, m_occ());
                fails++;
            end
            tests++;
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_degenerate();
        if ($bits(bus1.occ) != 2 || u_dut1.CNT_W != 2 || u_dut.CNT_W != 3) begin
            $display("FAIL cnt_w: got dut1=%0d bus1=%0d dut=%0d want 2 2 3",
                     u_dut1.CNT_W, $bits(bus1.occ), u_dut.CNT_W);
            fails++;
        end
        tests++;
        for (int k = 0; k < 40; k++) begin
            bus1.en      = ($urandom_range(4) != 0);
            bus1.flush   = ($urandom_range(9) == 0);
            bus1.d_valid = k[0] ^ ($urandom_range(5) == 0);
            bus1.d       = 1'($urandom);
            tick();
            if ({bus1.q_valid, bus1.q, bus1.occ} !== {m1_v, m1_d, 1'b0, m1_v}) begin
                $display("FAIL degenerate c%0d: got v=%b q=%b occ=%0d want v=%b q=%b occ=%0d",
                         k, bus1.q_valid, bus1.q, bus1.occ, m1_v, m1_d, m1_v);
                fails++;
            end
            tests++;
        end
        bus1.en = 1'b0; bus1.flush = 1'b0; bus1.d_valid = 1'b0; bus1.d = 1'b0;
    endtask

`ifdef PARAM_SHIFT_PIPE_PARITY_EN
    task automatic test_parity();
        drive(1'b1, 1'b0, 1'b1, 8'h0F); tick();
        drive(1'b1, 1'b0, 1'b1, 8'h33); tick();
        drive(1'b1, 1'b0, 1'b0, 8'h00); tick();
        force u_dut.s_q[2] = 8'h0E;
        tick();
        release u_dut.s_q[2];
        if ({bus.q_valid, bus.q, bus.perr} !== {1'b1, 8'h0E, 1'b0}) begin
            $display("FAIL parity_arrive: got v=%b q=%h perr=%b want v=1 q=0e perr=0",
                     bus.q_valid, bus.q, bus.perr);
            fails++;
        end
        tests++;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.perr !== 1'b1) begin
                $display("FAIL parity_sticky c%0d: got %b want 1", k, bus.perr);
                fails++;
            end
            tests++;
        end
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        if ({bus.perr, bus.occ} !== {1'b0, 3'd0}) begin
            $display("FAIL parity_flush: got perr=%b occ=%0d want 0 0", bus.perr, bus.occ);
            fails++;
        end
        tests++;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        rstn = 1'b0;
        #1 model_reset();
        rstn = 1'b1;
        tick();
    endtask
`else
    task automatic test_parity();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 1'b1, 8'($urandom));
            tick();
            if (bus.perr !== 1'b0) begin
                $display("FAIL perr_tied c%0d: got %b want 0", k, bus.perr);
                fails++;
            end
            tests++;
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rstn  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        bus1.en = 1'b0; bus1.flush = 1'b0; bus1.d_valid = 1'b0; bus1.d = 1'b0;
        model_reset();
        #12 rstn = 1'b1;
        #4;
        test_reset();
        test_fill_drain();
        test_stall();
        test_flush();
        test_degenerate();
        test_parity();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
